imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter AW, default 8: instruction memory address width.
REQ-002 Parameter DW, default 16: instruction word width.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive denied debug cycles before forced debug grant.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fetch_req  in  1 / fetch_addr  in  AW  fetch read request and address.
REQ-007 fetch_gnt  out  1 / fetch_valid  out  1 / fetch_rdata  out  DW  same-cycle grant, next-cycle data-valid pulse, registered read data.
REQ-008 dbg_req  in  1 / dbg_we  in  1 / dbg_lock  in  1 / dbg_addr  in  AW / dbg_wdata  in  DW  debug/loader request, write enable, burst lock, address, write data.
REQ-009 dbg_gnt  out  1 / dbg_valid  out  1 / dbg_rdata  out  DW  same-cycle grant, next-cycle completion pulse, registered read data.
REQ-010 fetch_stall  out  1  high while debug holds lock.
REQ-011 mem_addr  out  AW / mem_we  out  1 / mem_datain  out  DW / mem_dataout  in  DW  port to instruction memory (combinational read, synchronous write).
REQ-012 arb_state  out  2  current FSM state.

Function
REQ-013 FSM states: IDLE=0 (no grant last cycle), FETCH=1, DBG=2, LOCK=3; state = owner of last cycle's grant.
REQ-014 Non-LOCK grant priority each cycle: (a) dbg_req and starve_cnt==STARVE_LIMIT -> debug; (b) else fetch_req -> fetch; (c) else dbg_req -> debug; (d) else none.
REQ-015 At most one of fetch_gnt, dbg_gnt high in any cycle; grants are combinational from requests, starve_cnt and state.
REQ-016 mem_addr = granted requester's address; 0 when no grant; mem_we = dbg_gnt & dbg_we; mem_datain = dbg_wdata.
REQ-017 Granted read: mem_dataout captured at that clock edge into fetch_rdata/dbg_rdata; matching valid pulses high exactly one cycle after grant (latency 1).
REQ-018 Granted debug write: dbg_valid pulses one cycle after grant; dbg_rdata unchanged.
REQ-019 rdata registers hold value until next granted read of same requester.
REQ-020 starve_cnt: increment when dbg_req & !dbg_gnt, saturate at STARVE_LIMIT; clear when dbg_gnt or !dbg_req.
REQ-021 Debug grant with dbg_lock=1 -> next state LOCK.
REQ-022 In LOCK: fetch_gnt=0, dbg_gnt=dbg_req, fetch_stall=1; fetch requests wait, no starve counting for fetch.
REQ-023 In LOCK, cycle with dbg_lock=0 -> that cycle's request still serviced under lock, next state per REQ-013 (DBG if granted, else IDLE); fetch_stall drops with exit.
REQ-024 Requesters hold req/addr/data stable until gnt; deasserting req before gnt is legal and cancels the request.
REQ-025 Back-to-back grants to same or alternating requesters allowed every cycle; no dead cycle.

Reset
REQ-026 rst high: state=IDLE, starve_cnt=0, fetch_valid=0, dbg_valid=0, fetch_rdata=0, dbg_rdata=0 immediately (asynchronous).
REQ-027 While rst high: all grants 0, mem_we=0, mem_addr=0, fetch_stall=0; a pending valid pulse is dropped, not delivered after reset.

Structure
REQ-028 State encodings and default parameter values reside in shared definitions file def.v alongside opcode/register defines.
REQ-029 Saturating starvation counter is sub-module arb_starve_cnt (inputs inc, clr; output sat); rest flat.

Verification
REQ-030 Fetch only, addr 0x05, memory[5]=0x1234 -> fetch_gnt same cycle, fetch_valid next cycle, fetch_rdata=0x1234.
REQ-031 fetch_req and dbg_req held continuously (STARVE_LIMIT=4) -> 4 fetch grants, 5th cycle dbg_gnt, counter cleared, pattern repeats.
REQ-032 Debug write addr 0xBB data 0xA5A5 then fetch read 0xBB -> mem_we one cycle, dbg_valid pulse, fetch_rdata=0xA5A5.
REQ-033 dbg_lock=1 burst of 8 writes with fetch_req high -> fetch_gnt 0 and fetch_stall 1 throughout, arb_state=3; lock drop -> fetch granted within 1 cycle.
REQ-034 rst asserted in cycle after granted read -> fetch_valid never pulses, all outputs 0, arb_state=0.
REQ-035 No requests for 10 cycles -> no grants, mem_we=0, mem_addr=0, arb_state=0.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
//   Shared definitions for the instruction-memory arbiter. It holds the FSM
//   state encoding, the default parameter values and a helper that sizes the
//   starvation counter.
package imem_arbiter_pkg;

    // State records who owned the grant in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DBG   = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_t;

    localparam int DEF_AW           = 8;
    localparam int DEF_DW           = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    // Bits needed to hold 0..limit, with a minimum of one bit.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/imem_arbiter_starve_cnt.sv
// arb_starve_cnt
//   Saturating counter of consecutive denied debug cycles.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     inc      : debug requested but not granted this cycle
//     clr      : debug granted, or no debug request (clr wins over inc)
//     sat      : counter has reached LIMIT
module arb_starve_cnt
    import imem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int              CW      = starve_cnt_w(LIMIT);
    localparam logic [CW-1:0]   LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_V)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == LIMIT_V);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Arbitrates a single-port instruction memory between the instruction fetch
//   unit and a debug/loader port. Grants are combinational. Read data and
//   valid pulses are registered, so they arrive one cycle after the grant.
//   The debug port can lock the memory for bursts. A starvation counter
//   forces a debug grant after STARVE_LIMIT consecutive denied cycles.
//   Ports:
//     clk, rst                      : clock, asynchronous active-high reset
//     fetch_req/addr                : fetch read request
//     fetch_gnt/valid/rdata         : fetch grant, data-valid pulse, read data
//     dbg_req/we/lock/addr/wdata    : debug request, write enable, burst lock
//     dbg_gnt/valid/rdata           : debug grant, completion pulse, read data
//     fetch_stall                   : debug holds the lock
//     mem_addr/we/datain/dataout    : memory port (comb read, sync write)
//     arb_state                     : current FSM state
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_valid,
    output logic [DW-1:0] dbg_rdata,
    output logic          fetch_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout,
    output logic [1:0]    arb_state
);

    arb_state_t state;
    arb_state_t state_next;
    logic       starve_sat;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (dbg_req & ~dbg_gnt),
        .clr (dbg_gnt | ~dbg_req),
        .sat (starve_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next state. Reset is folded in so that no grant
    // or memory write can escape while rst is high.
    always_comb begin
        fetch_gnt  = 1'b0;
        dbg_gnt    = 1'b0;
        state_next = ST_IDLE;
        if (!rst) begin
            if (state == ST_LOCK) begin
                dbg_gnt = dbg_req;
            end else if (dbg_req && starve_sat) begin
                dbg_gnt = 1'b1;
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end

            // Lock persists while dbg_lock is held, even through idle debug
            // cycles. Outside the lock it is entered only on a debug grant.
            if ((state == ST_LOCK) ? dbg_lock : (dbg_gnt && dbg_lock)) begin
                state_next = ST_LOCK;
            end else if (dbg_gnt) begin
                state_next = ST_DBG;
            end else if (fetch_gnt) begin
                state_next = ST_FETCH;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr;
        end
    end

    assign mem_we      = dbg_gnt & dbg_we;
    assign mem_datain  = dbg_wdata;
    assign fetch_stall = (state == ST_LOCK) && !rst;
    assign arb_state   = state;

    // Read data and completion pulses, one cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            dbg_valid   <= 1'b0;
            fetch_rdata <= '0;
            dbg_rdata   <= '0;
        end else begin
            fetch_valid <= fetch_gnt;
            dbg_valid   <= dbg_gnt;
            if (fetch_gnt) begin
                fetch_rdata <= mem_dataout;
            end
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_dataout;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_rdata;
    logic          dbg_req;
    logic          dbg_we;
    logic          dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_valid;
    logic [DW-1:0] dbg_rdata;
    logic          fetch_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout;
    logic [1:0]    arb_state;

    int checks   = 0;
    int failures = 0;

    // Instruction memory seen by the DUT, and the bench's own copy.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    // Reference model state.
    logic [1:0]    m_state;
    int            m_cnt;
    logic          m_fg, m_dg, m_fv, m_dv;
    logic [DW-1:0] m_frd, m_drd;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] dq[$];

    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_datain;
    end

    imem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
        .fetch_stall(fetch_stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout), .arb_state(arb_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_cnt   = 0;
        m_fv    = 1'b0;
        m_dv    = 1'b0;
        m_frd   = '0;
        m_drd   = '0;
        fq.delete();
        dq.delete();
    endtask

    // One clock: check everything at the falling edge, then advance the
    // model on the rising edge and return 1 time unit later.
    task automatic tick();
        logic [AW-1:0] ea;
        @(negedge clk);
        if (m_fv) begin
            chk("fq_nonempty", fq.size(), 1);
            if (fq.size() > 0) m_frd = fq.pop_front();
        end
        if (m_dv) begin
            chk("dq_nonempty", dq.size(), 1);
            if (dq.size() > 0) m_drd = dq.pop_front();
        end
        m_fg = 1'b0;
        m_dg = 1'b0;
        if (!rst) begin
            if (m_state == 2'd3)                     m_dg = dbg_req;
            else if (dbg_req && m_cnt == LIMIT)      m_dg = 1'b1;
            else if (fetch_req)                      m_fg = 1'b1;
            else if (dbg_req)                        m_dg = 1'b1;
        end
        ea = m_fg ? fetch_addr : (m_dg ? dbg_addr : '0);
        chk("fetch_gnt",   fetch_gnt,   m_fg);
        chk("dbg_gnt",     dbg_gnt,     m_dg);
        chk("mem_addr",    mem_addr,    ea);
        chk("mem_we",      mem_we,      m_dg & dbg_we);
        chk("fetch_stall", fetch_stall, !rst && (m_state == 2'd3));
        chk("arb_state",   arb_state,   m_state);
        chk("fetch_valid", fetch_valid, m_fv);
        chk("dbg_valid",   dbg_valid,   m_dv);
        chk("fetch_rdata", fetch_rdata, m_frd);
        chk("dbg_rdata",   dbg_rdata,   m_drd);
        @(posedge clk);
        if (!rst) begin
            m_fv = m_fg;
            m_dv = m_dg;
            if (m_fg) fq.push_back(ref_mem[fetch_addr]);
            if (m_dg) begin
                if (dbg_we) begin
                    ref_mem[dbg_addr] = dbg_wdata;
                    dq.push_back(m_drd);
                end else begin
                    dq.push_back(ref_mem[dbg_addr]);
                end
            end
            if (m_dg || !dbg_req)  m_cnt = 0;
            else if (m_cnt < LIMIT) m_cnt++;
            if ((m_state == 2'd3) ? dbg_lock : (m_dg && dbg_lock)) m_state = 2'd3;
            else if (m_dg) m_state = 2'd2;
            else if (m_fg) m_state = 2'd1;
            else           m_state = 2'd0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        fetch_addr = '0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_lock   = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 16'h0101) ^ 16'h5A3C;
            ref_mem[i] = DW'(i * 16'h0101) ^ 16'h5A3C;
        end
        mem[5]     = 16'h1234;
        ref_mem[5] = 16'h1234;

        // Reset with requests pending: nothing may be granted.
        idle_inputs();
        fetch_req = 1'b1;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        rst       = 1'b1;
        model_reset();
        repeat (3) tick();
        idle_inputs();
        rst = 1'b0;
        tick();

        // Single fetch from address 0x05.
        fetch_req  = 1'b1;
        fetch_addr = 8'h05;
        tick();
        idle_inputs();
        tick();
        chk("fetch_0x05", fetch_rdata, 16'h1234);

        // Both requesters held: four fetches, then a forced debug read.
        fetch_req = 1'b1;
        dbg_req   = 1'b1;
        dbg_addr  = 8'h20;
        for (int i = 0; i < 15; i++) begin
            fetch_addr = AW'(8'h30 + i);
            tick();
        end
        idle_inputs();
        tick();

        // Debug write then fetch read-back of the same word.
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 8'hBB;
        dbg_wdata = 16'hA5A5;
        tick();
        idle_inputs();
        fetch_req  = 1'b1;
        fetch_addr = 8'hBB;
        tick();
        idle_inputs();
        tick();
        chk("wr_readback", fetch_rdata, 16'hA5A5);

        // Locked burst of eight writes while fetch keeps requesting.
        dbg_req  = 1'b1;
        dbg_we   = 1'b1;
        dbg_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbg_addr  = AW'(8'h40 + i);
            dbg_wdata = DW'(16'hC000 + i);
            fetch_req  = (i != 0);
            fetch_addr = 8'h10;
            tick();
            chk("lock_state", arb_state, 2'd3);
        end
        dbg_req  = 1'b0;
        dbg_we   = 1'b0;
        dbg_lock = 1'b0;
        tick();
        tick();
        fetch_addr = 8'h43;
        tick();
        idle_inputs();
        tick();
        chk("burst_readback", fetch_rdata, 16'hC003);

        // Random mix of both requesters, with occasional locks.
        for (int i = 0; i < 300; i++) begin
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = AW'($urandom_range(0, 255));
            dbg_req    = 1'($urandom_range(0, 1));
            dbg_we     = ($urandom_range(0, 3) == 0);
            dbg_lock   = ($urandom_range(0, 7) == 0);
            dbg_addr   = AW'($urandom_range(0, 255));
            dbg_wdata  = DW'($urandom_range(0, 65535));
            tick();
        end

        // Ten idle cycles.
        idle_inputs();
        repeat (10) tick();

        // Reset asserted after a read is granted: the valid must never appear.
        fetch_req  = 1'b1;
        fetch_addr = 8'h07;
        @(negedge clk);
        chk("pre_rst_gnt", fetch_gnt, 1'b1);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_no_valid", fetch_valid, 1'b0);
        repeat (2) tick();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
